// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host receiver.
//   Synchronises and deglitches the raw PS/2 clock and data lines. It decodes
//   11-bit frames (start, 8 data bits LSB first, odd parity, stop) and keeps the
//   last two good bytes as a 16-bit code.
// Ports:
//   clk         system clock
//   rst         synchronous reset, active-high
//   ps2_clk     raw PS/2 clock line (asynchronous, idle high)
//   ps2_data    raw PS/2 data line (asynchronous, idle high)
//   code        {previous byte, last byte}; shifts left 8 on each good frame
//   byte_valid  1-cycle pulse when code has just been updated
//   frame_err   1-cycle pulse on parity error, bad stop bit or timeout
//
// FSM states:
//   state  | meaning
//   IDLE   | waiting for a falling edge with data low (start bit)
//   DATA   | collecting the 8 data bits, LSB first
//   PARITY | capturing the parity bit
//   STOP   | checking parity and the stop bit, then publishing or flagging
module ps2_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] code,
  output logic        byte_valid,
  output logic        frame_err
);

  localparam int FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t state, state_next;

  logic clk_m, clk_s, data_m, data_s;
  logic clk_f, data_f, clk_f_q;
  logic [FW-1:0] clk_fcnt, data_fcnt;
  logic fall;

  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tmo_cnt;

  logic shift_en, par_en, frame_ok, frame_bad, tmo_hit;

  // Two-flop synchronisers; reset to the idle-high bus level.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_m  <= 1'b1;
      clk_s  <= 1'b1;
      data_m <= 1'b1;
      data_s <= 1'b1;
    end else begin
      clk_m  <= ps2_clk;
      clk_s  <= clk_m;
      data_m <= ps2_data;
      data_s <= data_m;
    end
  end

  // The filter counts samples that disagree with the filtered value. The
  // filtered value flips on the FILTER_LEN-th consecutive disagreeing sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_f    <= 1'b1;
      clk_fcnt <= '0;
    end else if (clk_s == clk_f) begin
      clk_fcnt <= '0;
    end else if (clk_fcnt == FLT_LAST) begin
      clk_f    <= clk_s;
      clk_fcnt <= '0;
    end else begin
      clk_fcnt <= clk_fcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_f    <= 1'b1;
      data_fcnt <= '0;
    end else if (data_s == data_f) begin
      data_fcnt <= '0;
    end else if (data_fcnt == FLT_LAST) begin
      data_f    <= data_s;
      data_fcnt <= '0;
    end else begin
      data_fcnt <= data_fcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) clk_f_q <= 1'b1;
    else     clk_f_q <= clk_f;
  end

  assign fall    = clk_f_q & ~clk_f;
  assign tmo_hit = (state != IDLE) && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    par_en     = 1'b0;
    frame_ok   = 1'b0;
    frame_bad  = 1'b0;
    case (state)
      IDLE: begin
        if (fall && !data_f) state_next = DATA;
      end
      DATA: begin
        if (fall) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_next = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          par_en     = 1'b1;
          state_next = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          // Odd parity: data bits plus parity bit must hold an odd number of ones.
          if ((^{shreg, par_bit}) && data_f) frame_ok  = 1'b1;
          else                               frame_bad = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // An edge in the same cycle as the timeout takes priority.
    if (tmo_hit && !fall) begin
      state_next = IDLE;
      frame_bad  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tmo_cnt    <= '0;
      code       <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (state == IDLE)  bit_cnt <= '0;
      else if (shift_en)  bit_cnt <= bit_cnt + 1'b1;

      if (shift_en) shreg[bit_cnt] <= data_f;
      if (par_en)   par_bit        <= data_f;

      if (state == IDLE || fall) tmo_cnt <= '0;
      else                       tmo_cnt <= tmo_cnt + 1'b1;

      if (frame_ok) code <= {code[7:0], shreg};
      byte_valid <= frame_ok;
      frame_err  <= frame_bad;
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: self-checking bench for ps2_rx.
//   Drives PS/2 frames with random bytes and bit periods, and injects parity,
//   stop-bit, glitch, timeout and reset cases. It compares code and the pulse
//   counts against a byte-level reference model.
module tb_ps2_rx;

  localparam int FL  = 8;
  localparam int TMO = 2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] code;
  logic        byte_valid;
  logic        frame_err;

  ps2_rx #(.FILTER_LEN(FL), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .code(code), .byte_valid(byte_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_err    = 0;
  logic both_high = 1'b0, valid_long = 1'b0, err_long = 1'b0;
  logic prev_valid = 1'b0, prev_err = 1'b0;

  logic [15:0] exp_code = 16'h0000;
  int h = 40;

  // Pulse monitor: counts pulses and flags overlap or pulses longer than one cycle.
  always @(negedge clk) begin
    if (byte_valid) n_valid++;
    if (frame_err)  n_err++;
    if (byte_valid && frame_err) both_high = 1'b1;
    if (byte_valid && prev_valid) valid_long = 1'b1;
    if (frame_err && prev_err)    err_long   = 1'b1;
    prev_valid = byte_valid;
    prev_err   = frame_err;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One bit: data set while clock is high, then a low half period.
  task automatic send_bit(input logic d, input bit glitch);
    @(negedge clk);
    ps2_data = d;
    wait_cyc(h / 2);
    if (glitch) begin
      ps2_clk = 1'b0;
      wait_cyc(FL - 2);
      ps2_clk = 1'b1;
    end
    wait_cyc(h / 2);
    ps2_clk = 1'b0;
    wait_cyc(h);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip,
                            input logic stop, input int glitch_bit);
    logic [10:0] bits;
    bits = {stop, (~^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(bits[i], i == glitch_bit);
    @(negedge clk);
    ps2_data = 1'b1;
  endtask

  // Sends a frame, updates the reference model and checks the result.
  task automatic run_frame(input string tag, input logic [7:0] b, input logic par_flip,
                           input logic stop, input int glitch_bit);
    int v0, e0;
    logic good;
    v0 = n_valid;
    e0 = n_err;
    send_frame(b, par_flip, stop, glitch_bit);
    good = !par_flip && stop;
    if (good) exp_code = {exp_code[7:0], b};
    wait_cyc(30);
    chk({tag, "_valid"}, 32'(n_valid - v0), good ? 32'd1 : 32'd0);
    chk({tag, "_err"},   32'(n_err - e0),   good ? 32'd0 : 32'd1);
    chk({tag, "_code"},  {16'h0, code},     {16'h0, exp_code});
  endtask

  initial begin
    int v0, e0;
    logic [7:0] rb;
    logic pf, sb;

    // Reset values.
    wait_cyc(5);
    chk("rst_code",  {16'h0, code}, 32'h0);
    chk("rst_valid", {31'h0, byte_valid}, 32'h0);
    chk("rst_err",   {31'h0, frame_err},  32'h0);
    rst = 1'b0;
    wait_cyc(20);

    // Basic frames and code shifting.
    h = 40;
    run_frame("f1c", 8'h1C, 1'b0, 1'b1, -1);
    run_frame("ff0", 8'hF0, 1'b0, 1'b1, -1);
    run_frame("f1c2", 8'h1C, 1'b0, 1'b1, -1);
    chk("seq_code", {16'h0, code}, 32'h0000_F01C);

    // Parity error, then a good frame.
    run_frame("par", 8'h1C, 1'b1, 1'b1, -1);
    run_frame("f32", 8'h32, 1'b0, 1'b1, -1);
    chk("f32_low", {24'h0, code[7:0]}, 32'h32);

    // Bad stop bit.
    run_frame("stop", 8'hA5, 1'b0, 1'b0, -1);

    // Short clock glitch must not consume a bit.
    run_frame("glitch", 8'h6B, 1'b0, 1'b1, 4);

    // Timeout after start + 4 data bits.
    v0 = n_valid;
    e0 = n_err;
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    @(negedge clk);
    ps2_data = 1'b1;
    wait_cyc(TMO + 10);
    chk("tmo_err",   32'(n_err - e0),   32'd1);
    chk("tmo_valid", 32'(n_valid - v0), 32'd0);
    run_frame("f5a", 8'h5A, 1'b0, 1'b1, -1);
    chk("f5a_low", {24'h0, code[7:0]}, 32'h5A);

    // Reset mid-frame.
    v0 = n_valid;
    e0 = n_err;
    send_bit(1'b0, 0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
    @(negedge clk);
    ps2_data = 1'b1;
    rst = 1'b1;
    wait_cyc(5);
    rst = 1'b0;
    exp_code = 16'h0000;
    wait_cyc(30);
    chk("mrst_code",  {16'h0, code}, 32'h0);
    chk("mrst_valid", 32'(n_valid - v0), 32'd0);
    chk("mrst_err",   32'(n_err - e0),   32'd0);

    // False start on an idle bus.
    send_bit(1'b1, 0);
    wait_cyc(30);
    chk("fstart_valid", 32'(n_valid - v0), 32'd0);
    chk("fstart_err",   32'(n_err - e0),   32'd0);
    run_frame("after_rst", 8'h3C, 1'b0, 1'b1, -1);

    // Random frames with random bit periods and occasional corruption.
    for (int k = 0; k < 16; k++) begin
      h  = int'($urandom_range(30, 50));
      rb = 8'($urandom);
      pf = ($urandom_range(0, 3) == 0);
      sb = ($urandom_range(0, 5) != 0);
      run_frame("rand", rb, pf, sb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1);
    end

    chk("both_high",   {31'h0, both_high},  32'h0);
    chk("valid_width", {31'h0, valid_long}, 32'h0);
    chk("err_width",   {31'h0, err_long},   32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
